// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Conditions a raw board pushbutton into clean single-cycle events. It sits
//   directly behind the KEY pin in the CLK50 domain. The pin is brought to a
//   common polarity (1 = pressed) and then synchronised. After that, a
//   four-state FSM with a debounce timer accepts a level only once it has been
//   stable for DEBOUNCE_CYCLES samples. A hold timer raises LONG once per
//   press, when the key has stayed pressed for LONGPRESS_CYCLES.
//
// Ports
//   CLK50      in   1      system clock
//   RST        in   1      asynchronous reset, active-high
//   KEY        in   1      raw asynchronous button pin
//   KEY_LEVEL  out  1      debounced level, 1 = pressed
//   PRESS      out  1      one-cycle pulse on accepted press
//   RELEASE    out  1      one-cycle pulse on accepted release
//   LONG       out  1      one-cycle pulse, once per press, after a long hold
//   PRESS_CNT  out  CNT_W  accepted presses, modulo 2^CNT_W
//   LED0       out  1      toggles on every accepted press
// -----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES  = 1000000,
   parameter int LONGPRESS_CYCLES = 50000000,
   parameter int CNT_W            = 8,
   parameter int ACTIVE_LOW       = 1
) (
   input  logic             CLK50,
   input  logic             RST,
   input  logic             KEY,
   output logic             KEY_LEVEL,
   output logic             PRESS,
   output logic             RELEASE,
   output logic             LONG,
   output logic [CNT_W-1:0] PRESS_CNT,
   output logic             LED0
);

   localparam int TMR_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = $clog2(LONGPRESS_CYCLES + 1);

   localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONGPRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONGPRESS_CYCLES - 1);
   localparam logic              POL       = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   state_t             state;
   logic [TMR_W-1:0]   timer;
   logic [HOLD_W-1:0]  hold;
   logic               key_p0;
   logic               key_p1;

   // Stage p0/p1: polarity normalisation and two-flop synchroniser
   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         key_p0 <= 1'b0;
         key_p1 <= 1'b0;
      end else begin
         key_p0 <= KEY ^ POL;
         key_p1 <= key_p0;
      end
   end

   // Stage p2: debounce FSM, timers and registered event outputs
   always_ff @(posedge CLK50 or posedge RST) begin
      if (RST) begin
         state     <= RELEASED;
         timer     <= '0;
         hold      <= '0;
         KEY_LEVEL <= 1'b0;
         PRESS     <= 1'b0;
         RELEASE   <= 1'b0;
         LONG      <= 1'b0;
         PRESS_CNT <= '0;
         LED0      <= 1'b0;
      end else begin
         PRESS   <= 1'b0;
         RELEASE <= 1'b0;
         LONG    <= 1'b0;
         case (state)
            RELEASED: begin
               if (key_p1) begin
                  state <= PRESS_WAIT;
                  timer <= TMR_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!key_p1) begin
                  // Bounce: drop back silently.
                  state <= RELEASED;
               end else if (timer == TMR_LAST) begin
                  state     <= PRESSED;
                  PRESS     <= 1'b1;
                  KEY_LEVEL <= 1'b1;
                  PRESS_CNT <= PRESS_CNT + 1'b1;
                  LED0      <= ~LED0;
                  hold      <= '0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PRESSED: begin
               if (!key_p1) begin
                  state <= RELEASE_WAIT;
                  timer <= TMR_ONE;
               end else if (hold != HOLD_MAX) begin
                  // Saturating at HOLD_MAX means LONG fires only on the
                  // single step into saturation, so once per press.
                  hold <= hold + 1'b1;
                  if (hold == HOLD_LAST) begin
                     LONG <= 1'b1;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (key_p1) begin
                  // Release bounce: hold is kept, so LONG is not re-armed.
                  state <= PRESSED;
               end else if (timer == TMR_LAST) begin
                  state     <= RELEASED;
                  RELEASE   <= 1'b1;
                  KEY_LEVEL <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
            end
         endcase
      end
   end

endmodule
